// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: START/PLAY/OVER screen state, button edge handling,
// flap pulses, and current/best score. State changes only on frame_tick.
module game_state_ctrl #(
  parameter int SCORE_W          = 14,
  parameter int MAX_SCORE        = 9999,
  parameter int OVER_HOLD_FRAMES = 60,
  parameter int HOLD_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn,
  input  logic               collision,
  input  logic               pipe_pass,
  output logic [1:0]         state,
  output logic               game_rst,
  output logic               flap,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(OVER_HOLD_FRAMES);

  state_t              state_q, state_d;
  logic                btn_q;
  logic                btn_rise;
  logic                start_pend_q, start_pend_d;
  logic                hit_pend_q, hit_pend_d;
  logic                restart_pend_q, restart_pend_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                game_rst_q, game_rst_d;
  logic                flap_q, flap_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  best_q, best_d;

  assign btn_rise = btn & ~btn_q;

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset
  // checked first, so rst wins over every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_START;
      btn_q          <= 1'b0;
      start_pend_q   <= 1'b0;
      hit_pend_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      hold_q         <= '0;
      game_rst_q     <= 1'b0;
      flap_q         <= 1'b0;
      score_q        <= '0;
      best_q         <= '0;
    end else begin
      state_q        <= state_d;
      btn_q          <= btn;
      start_pend_q   <= start_pend_d;
      hit_pend_q     <= hit_pend_d;
      restart_pend_q <= restart_pend_d;
      hold_q         <= hold_d;
      game_rst_q     <= game_rst_d;
      flap_q         <= flap_d;
      score_q        <= score_d;
      best_q         <= best_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    start_pend_d   = start_pend_q;
    hit_pend_d     = hit_pend_q;
    restart_pend_d = restart_pend_q;
    hold_d         = hold_q;
    game_rst_d     = 1'b0;
    flap_d         = 1'b0;
    score_d        = score_q;
    best_d         = best_q;

    case (state_q)
      ST_START: begin
        if (frame_tick && (start_pend_q || btn_rise)) begin
          state_d    = ST_PLAY;
          game_rst_d = 1'b1;
          score_d    = '0;
        end else if (btn_rise) begin
          start_pend_d = 1'b1;
        end
      end

      ST_PLAY: begin
        flap_d = btn_rise;
        if (pipe_pass) begin
          score_d = (score_q >= MAX_S) ? MAX_S : score_q + SCORE_W'(1);
        end
        // score_d already includes a same-cycle pipe_pass when best is compared.
        if (frame_tick && (hit_pend_q || collision)) begin
          state_d = ST_OVER;
          hold_d  = HOLD_INIT;
          if (score_d > best_q) begin
            best_d = score_d;
          end
        end else if (collision) begin
          hit_pend_d = 1'b1;
        end
      end

      ST_OVER: begin
        // Presses are only seen once hold already reads zero, so the tick that
        // counts hold down to zero can never also accept a press.
        if (hold_q != '0) begin
          if (frame_tick) begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end else if (frame_tick && (restart_pend_q || btn_rise)) begin
          state_d = ST_START;
        end else if (btn_rise) begin
          restart_pend_d = 1'b1;
        end
      end

      default: state_d = ST_START;
    endcase

    if (state_d != state_q) begin
      start_pend_d   = 1'b0;
      hit_pend_d     = 1'b0;
      restart_pend_d = 1'b0;
    end
  end

  assign state      = state_q;
  assign game_rst   = game_rst_q;
  assign flap       = flap_q;
  assign score      = score_q;
  assign best_score = best_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios with literal
// expectations, then randomized play checked every cycle against a game model.
module tb_game_state_ctrl;

  localparam int T_SCORE_W = 14;
  localparam int T_MAX     = 7;
  localparam int T_HOLD    = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 frame_tick = 1'b0;
  logic                 btn = 1'b0;
  logic                 collision = 1'b0;
  logic                 pipe_pass = 1'b0;
  logic [1:0]           state;
  logic                 game_rst;
  logic                 flap;
  logic [T_SCORE_W-1:0] score;
  logic [T_SCORE_W-1:0] best_score;

  int n_tests = 0;
  int n_fail  = 0;

  game_state_ctrl #(
    .SCORE_W         (T_SCORE_W),
    .MAX_SCORE       (T_MAX),
    .OVER_HOLD_FRAMES(T_HOLD),
    .HOLD_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn       (btn),
    .collision (collision),
    .pipe_pass (pipe_pass),
    .state     (state),
    .game_rst  (game_rst),
    .flap      (flap),
    .score     (score),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: mode 0=START 1=PLAY 2=OVER; one "request" flag per mode.
  int m_mode, m_req, m_hold, m_score, m_best;
  bit m_grst, m_flap, m_prev, m_valid = 1'b0;

  always @(posedge clk) begin : model
    int  md, rq, hd, sc, bs;
    bit  gr, fl, rise;
    if (rst) begin
      m_mode  <= 0; m_req <= 0; m_hold <= 0; m_score <= 0; m_best <= 0;
      m_grst  <= 1'b0; m_flap <= 1'b0; m_prev <= 1'b0; m_valid <= 1'b1;
    end else begin
      md = m_mode; rq = m_req; hd = m_hold; sc = m_score; bs = m_best;
      gr = 1'b0; fl = 1'b0;
      rise = btn && !m_prev;
      if (md == 0) begin
        if (frame_tick && (rq != 0 || rise)) begin
          md = 1; gr = 1'b1; sc = 0; rq = 0;
        end else if (rise) rq = 1;
      end else if (md == 1) begin
        fl = rise;
        if (pipe_pass) sc = (sc < T_MAX) ? sc + 1 : T_MAX;
        if (frame_tick && (rq != 0 || collision)) begin
          md = 2; rq = 0; hd = T_HOLD;
          if (sc > bs) bs = sc;
        end else if (collision) rq = 1;
      end else begin
        if (hd > 0) begin
          if (frame_tick) hd = hd - 1;
        end else if (frame_tick && (rq != 0 || rise)) begin
          md = 0; rq = 0;
        end else if (rise) rq = 1;
      end
      m_mode <= md; m_req <= rq; m_hold <= hd; m_score <= sc; m_best <= bs;
      m_grst <= gr; m_flap <= fl; m_prev <= btn;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle {state,game_rst,flap,score,best}",
            {state, game_rst, flap, score, best_score},
            {2'(m_mode), m_grst, m_flap, T_SCORE_W'(m_score), T_SCORE_W'(m_best)});
    end
  end

  task automatic cyc(input logic ft, input logic b, input logic col, input logic pp);
    frame_tick = ft; btn = b; collision = col; pipe_pass = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic exit_over();
    for (int i = 0; i < T_HOLD; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("exit_over state", 32'(state), 32'd0);
  endtask

  initial begin
    int nflap;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    check("reset outputs", {state, game_rst, flap, score, best_score}, 32'd0);

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("pending press waits for tick", 32'(state), 32'd0);
    cyc(1, 0, 0, 0);
    check("start -> play", {state, game_rst, flap, score}, {2'b01, 1'b1, 1'b0, 14'd0});
    cyc(0, 0, 0, 0);
    check("game_rst single pulse", 32'(game_rst), 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check("press flap high", 32'(flap), 32'd1);
      cyc(0, 0, 0, 0);
      check("press flap low", 32'(flap), 32'd0);
    end

    nflap = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, 0, 0);
      if (flap) nflap++;
    end
    cyc(0, 0, 0, 0);
    check("long hold gives one flap", 32'(nflap), 32'd1);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    check("five pipes", 32'(score), 32'd5);

    cyc(0, 0, 1, 0);
    check("collision waits for tick", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("game over state/best", {state, score, best_score}, {2'b10, 14'd5, 14'd5});

    for (int i = 0; i < T_HOLD; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("press ignored during hold", 32'(state), 32'd2);
    end
    cyc(1, 0, 0, 0);
    check("tick without press stays over", 32'(state), 32'd2);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 0);
    check("score frozen in over", {state, score}, {2'b10, 14'd5});
    cyc(1, 0, 0, 0);
    check("restart -> start", {state, score, best_score}, {2'b00, 14'd5, 14'd5});

    start_game();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 0);
    check("second game keeps best", {state, score, best_score}, {2'b10, 14'd2, 14'd5});
    exit_over();

    start_game();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    check("score saturates", 32'(score), 32'(T_MAX));
    cyc(1, 0, 1, 1);
    check("saturated best", {state, score, best_score}, {2'b10, 14'd7, 14'd7});
    exit_over();

    start_game();
    cyc(0, 0, 0, 1);
    rst = 1'b1;
    cyc(0, 1, 1, 1);
    rst = 1'b0;
    check("rst mid-play", {state, game_rst, flap, score, best_score}, 32'd0);
    cyc(0, 0, 0, 0);
    check("no pulses after rst", {state, game_rst, flap}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic b;
      b = ($urandom_range(0, 3) == 0) ? ~btn : btn;
      rst = ($urandom_range(0, 799) == 0);
      cyc($urandom_range(0, 5) == 0, b, $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer. It owns the three-screen state (START / PLAY / OVER) that drives the display-source selector, and it changes state only on frame boundaries. It turns the raw button into start requests and flap pulses, and keeps the current and best score. It sits between the input synchronizers and collision/pipe logic on one side, and the renderers plus the RGB source mux on the other.

## Interface
- SCORE_W, 14, width of score outputs
- MAX_SCORE, 9999, saturation value of score
- OVER_HOLD_FRAMES, 60, frames in OVER during which the button is ignored
- HOLD_W, 8, width of hold counter (must hold OVER_HOLD_FRAMES)

- clk  in  1  system/pixel clock
- rst  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn  in  1  button level, already synchronized to clk
- collision  in  1  one-cycle pulse: bird hit pipe/ground
- pipe_pass  in  1  one-cycle pulse: bird cleared a pipe
- state  out  2  00 START, 01 PLAY, 10 OVER; 11 never driven
- game_rst  out  1  one-cycle pulse on entry to PLAY (resets bird/pipe logic)
- flap  out  1  one-cycle pulse per button press while in PLAY
- score  out  SCORE_W  current score
- best_score  out  SCORE_W  highest score since rst

## Operation
- Button edge: btn_q register (reset 0); btn_rise = btn & ~btn_q. Holding btn gives exactly one rise.
- START: a btn_rise sets start_pend. At an edge where frame_tick=1 and (start_pend | btn_rise), the block:
  - sets state←PLAY and game_rst←1 for one cycle;
  - sets score←0;
  - clears start_pend.
- PLAY:
  - btn_rise → flap=1 for the next cycle. The press that started the game does not produce a flap.
  - pipe_pass → score+1, saturating at MAX_SCORE.
  - collision sets hit_pend. At an edge where frame_tick=1 and (hit_pend | collision):
    - state←OVER, hit_pend cleared;
    - hold←OVER_HOLD_FRAMES;
    - if the final score (including a pipe_pass in the same cycle) > best_score, best_score←that score.
- OVER:
  - score is frozen; pipe_pass, collision and flap are ignored.
  - Each frame_tick decrements hold while hold≠0.
  - While hold≠0, btn_rise is discarded, not latched.
  - When hold=0, btn_rise sets restart_pend. At an edge where frame_tick=1 and (restart_pend | btn_rise), state←START and restart_pend is cleared. The hold decrement to 0 and the acceptance of a press are not allowed in the same cycle.
- Pending flags are cleared on every state change. Events arriving for a state the block is not in are ignored.
- best_score persists across games; only rst clears it.

## Timing
- All outputs are registered. Reset values:
  - state=00, game_rst=0, flap=0, score=0, best_score=0;
  - internal: hold=0, all pend flags=0, btn_q=0.
- rst dominates every other input in the same cycle. rst mid-game returns to START with scores cleared; no game_rst pulse is issued.
- State latency: state changes on the clk edge that samples frame_tick=1 with a qualifying request. It never changes without frame_tick.
- game_rst is asserted exactly in the first cycle state reads 01.
- flap latency: 1 cycle after the edge that sampled btn_rise. At most one flap per press.
- score latency: updates 1 cycle after the pipe_pass edge. Saturation holds MAX_SCORE; there is no wrap.
- collision and pipe_pass in the same PLAY cycle: both take effect; the score increment happens first.
- OVER_HOLD_FRAMES=0: a button press is accepted immediately in OVER.

## Test plan
- Reset then idle: state=00, all outputs 0. A btn press between ticks sets start_pend; the next frame_tick gives state=01 with a single game_rst pulse, score=0, and no flap.
- PLAY: 3 separate presses give 3 one-cycle flap pulses. A 50-cycle btn hold gives 1 flap. 5 pipe_pass pulses give score=5.
- Saturation: with MAX_SCORE=3, 5 pipe_pass pulses give score=3 with no wrap.
- Game over:
  - collision at score=5 with best=0: state stays 01 until the next frame_tick, then 10 and best=5;
  - a second game ending at score=2 leaves best=5.
- OVER hold: with OVER_HOLD_FRAMES=4, presses during frames 1-4 are ignored. A press after 4 ticks, then the next tick, gives state=00. score stays at the final value throughout OVER.
- rst asserted mid-PLAY together with collision and btn: next cycle state=00, score=0, best=0, no game_rst, no flap.
